// File: rtl/hb_rwds_wr_ctrl.sv
// RWDS sequencer for one HyperBus transaction: samples the latency request at the
// end of CA, then drives the per-byte write mask with its preamble during DATA.

module hb_rwds_wr_ctrl_chk (
  input logic       clk,
  input logic       rst,
  input logic       cmd_ready,
  input logic       busy,
  input logic       done,
  input logic       underrun,
  input logic       wdata_ready,
  input logic       rwds_t,
  input logic [1:0] rwds_sdr
);

  a_ready_busy: assert property (@(posedge clk) disable iff (rst) cmd_ready != busy)
    else $error("cmd_ready and busy overlap");

  a_done_idle: assert property (@(posedge clk) disable iff (rst) done |=> !busy)
    else $error("busy after done");

  a_done_pulse: assert property (@(posedge clk) disable iff (rst) done |=> !done)
    else $error("done longer than one cycle");

  a_ready_drive: assert property (@(posedge clk) disable iff (rst) wdata_ready |-> !rwds_t)
    else $error("strobe accepted while RWDS released");

  a_underrun_mask: assert property (@(posedge clk) disable iff (rst)
                                    underrun |-> (rwds_sdr == 2'b11 && !rwds_t))
    else $error("underrun without full mask");

  a_hiz_quiet: assert property (@(posedge clk) disable iff (rst) rwds_t |-> rwds_sdr == 2'b00)
    else $error("mask bits active while released");

endmodule

module hb_rwds_wr_ctrl #(
  parameter int LATENCY_CYCLES = 6,
  parameter bit FIXED_LATENCY  = 1'b0,
  parameter int LEN_WIDTH      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_wr,
  input  logic                 cmd_zlat,
  input  logic [LEN_WIDTH-1:0] cmd_len,
  input  logic                 rwds_sampled,
  input  logic                 wdata_valid,
  input  logic [1:0]           wdata_strb,
  output logic                 wdata_ready,
  output logic                 rwds_t,
  output logic [1:0]           rwds_sdr,
  output logic                 lat_2x,
  output logic                 busy,
  output logic                 done,
  output logic                 underrun
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_CA   = 3'd1;
  localparam logic [2:0] ST_LAT  = 3'd2;
  localparam logic [2:0] ST_DATA = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  // Counter loads are N-1 so LAT exits on the cycle the counter reads zero.
  localparam logic [4:0] LAT_1X_LOAD = 5'(LATENCY_CYCLES - 1);
  localparam logic [4:0] LAT_2X_LOAD = 5'(2 * LATENCY_CYCLES - 1);
  localparam logic [LEN_WIDTH-1:0] WORD_ONE = {{(LEN_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [LEN_WIDTH-1:0] WORD_ZERO = {LEN_WIDTH{1'b0}};

  logic [2:0]           state_r,    state_s;
  logic [1:0]           ca_cnt_r,   ca_cnt_s;
  logic [4:0]           lat_cnt_r,  lat_cnt_s;
  logic [LEN_WIDTH-1:0] word_cnt_r, word_cnt_s;
  logic [LEN_WIDTH-1:0] len_r,      len_s;
  logic                 wr_r,       wr_s;
  logic                 zlat_r,     zlat_s;
  logic                 lat_2x_r,   lat_2x_s;
  logic                 rwds_t_r,   rwds_t_s;
  logic [1:0]           rwds_sdr_r, rwds_sdr_s;
  logic                 done_r,     done_s;
  logic                 underrun_r, underrun_s;
  logic                 mask_en_s;
  logic                 lat_pick_s;

  assign mask_en_s  = wr_r & ~zlat_r;
  assign lat_pick_s = FIXED_LATENCY ? 1'b1 : rwds_sampled;

  assign cmd_ready   = (state_r == ST_IDLE);
  assign busy        = (state_r != ST_IDLE);
  assign wdata_ready = (state_r == ST_DATA) & mask_en_s;
  assign rwds_t      = rwds_t_r;
  assign rwds_sdr    = rwds_sdr_r;
  assign lat_2x      = lat_2x_r;
  assign done        = done_r;
  assign underrun    = underrun_r;

  // Next-state and next-output computation; RWDS idles released with no mask.
  always_comb begin
    state_s    = state_r;
    ca_cnt_s   = ca_cnt_r;
    lat_cnt_s  = lat_cnt_r;
    word_cnt_s = word_cnt_r;
    len_s      = len_r;
    wr_s       = wr_r;
    zlat_s     = zlat_r;
    lat_2x_s   = lat_2x_r;
    rwds_t_s   = 1'b1;
    rwds_sdr_s = 2'b00;
    done_s     = 1'b0;
    underrun_s = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (cmd_valid) begin
          wr_s     = cmd_wr;
          zlat_s   = cmd_zlat;
          len_s    = cmd_len;
          ca_cnt_s = 2'd0;
          state_s  = ST_CA;
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_CA: begin
        if (ca_cnt_r == 2'd2) begin
          lat_2x_s   = lat_pick_s;
          word_cnt_s = WORD_ZERO;
          if (zlat_r) begin
            state_s = ST_DATA;
          end else begin
            lat_cnt_s = lat_pick_s ? LAT_2X_LOAD : LAT_1X_LOAD;
            state_s   = ST_LAT;
          end
        end else begin
          ca_cnt_s = ca_cnt_r + 2'd1;
        end
      end

      ST_LAT: begin
        if (lat_cnt_r == 5'd0) begin
          // Preamble: take the pin one cycle ahead of the first mask.
          rwds_t_s = ~mask_en_s;
          state_s  = ST_DATA;
        end else begin
          lat_cnt_s = lat_cnt_r - 5'd1;
        end
      end

      ST_DATA: begin
        if (mask_en_s) begin
          rwds_t_s   = 1'b0;
          rwds_sdr_s = wdata_valid ? ~wdata_strb : 2'b11;
          underrun_s = ~wdata_valid;
        end else begin
          rwds_t_s   = 1'b1;
          rwds_sdr_s = 2'b00;
        end
        // Compare before incrementing so an all-ones length never wraps early.
        if (word_cnt_r == len_r) begin
          done_s  = 1'b1;
          state_s = ST_DONE;
        end else begin
          word_cnt_s = word_cnt_r + WORD_ONE;
        end
      end

      ST_DONE: begin
        state_s = ST_IDLE;
      end

      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      ca_cnt_r   <= 2'd0;
      lat_cnt_r  <= 5'd0;
      word_cnt_r <= WORD_ZERO;
      len_r      <= WORD_ZERO;
      wr_r       <= 1'b0;
      zlat_r     <= 1'b0;
      lat_2x_r   <= 1'b0;
      rwds_t_r   <= 1'b1;
      rwds_sdr_r <= 2'b00;
      done_r     <= 1'b0;
      underrun_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      ca_cnt_r   <= ca_cnt_s;
      lat_cnt_r  <= lat_cnt_s;
      word_cnt_r <= word_cnt_s;
      len_r      <= len_s;
      wr_r       <= wr_s;
      zlat_r     <= zlat_s;
      lat_2x_r   <= lat_2x_s;
      rwds_t_r   <= rwds_t_s;
      rwds_sdr_r <= rwds_sdr_s;
      done_r     <= done_s;
      underrun_r <= underrun_s;
    end
  end

  hb_rwds_wr_ctrl_chk u_chk (
    .clk         (clk),
    .rst         (rst),
    .cmd_ready   (cmd_ready),
    .busy        (busy),
    .done        (done),
    .underrun    (underrun),
    .wdata_ready (wdata_ready),
    .rwds_t      (rwds_t),
    .rwds_sdr    (rwds_sdr)
  );

endmodule

// File: tb/tb_hb_rwds_wr_ctrl.sv
// Bench for hb_rwds_wr_ctrl: a transaction-level timing model checks every cycle,
// directed scenarios are pinned with literal cycle numbers, then random traffic runs.

module tb_hb_rwds_wr_ctrl;
  localparam int LC = 6;
  localparam int LW = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rst, cmd_valid, cmd_ready, cmd_wr, cmd_zlat, rwds_sampled, wdata_valid;
  logic [LW-1:0] cmd_len;
  logic [1:0] wdata_strb, rwds_sdr;
  logic wdata_ready, rwds_t, lat_2x, busy, done, underrun;

  logic f_rst, f_cmd_valid, f_cmd_ready, f_cmd_wr, f_cmd_zlat, f_rwds_sampled, f_wdata_valid;
  logic [15:0] f_cmd_len;
  logic [1:0] f_wdata_strb, f_rwds_sdr;
  logic f_wdata_ready, f_rwds_t, f_lat_2x, f_busy, f_done, f_underrun;

  hb_rwds_wr_ctrl #(.LATENCY_CYCLES(LC), .FIXED_LATENCY(1'b0), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_zlat(cmd_zlat), .cmd_len(cmd_len), .rwds_sampled(rwds_sampled),
    .wdata_valid(wdata_valid), .wdata_strb(wdata_strb), .wdata_ready(wdata_ready),
    .rwds_t(rwds_t), .rwds_sdr(rwds_sdr), .lat_2x(lat_2x), .busy(busy), .done(done),
    .underrun(underrun));

  hb_rwds_wr_ctrl #(.LATENCY_CYCLES(LC), .FIXED_LATENCY(1'b1), .LEN_WIDTH(16)) dut_fix (
    .clk(clk), .rst(f_rst), .cmd_valid(f_cmd_valid), .cmd_ready(f_cmd_ready), .cmd_wr(f_cmd_wr),
    .cmd_zlat(f_cmd_zlat), .cmd_len(f_cmd_len), .rwds_sampled(f_rwds_sampled),
    .wdata_valid(f_wdata_valid), .wdata_strb(f_wdata_strb), .wdata_ready(f_wdata_ready),
    .rwds_t(f_rwds_t), .rwds_sdr(f_rwds_sdr), .lat_2x(f_lat_2x), .busy(f_busy), .done(f_done),
    .underrun(f_underrun));

  int errs = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] pat(input int j);
    case (j % 4)
      0: return 2'b11;
      1: return 2'b01;
      2: return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  // Table mode drives the fixed strobe pattern indexed from the first DATA cycle.
  task automatic drive_w(input int d0, input int gap, input bit rnd);
    int j;
    j = cyc - d0;
    if (!rnd && j >= 0) begin
      wdata_valid = (j != gap);
      wdata_strb  = pat(j);
    end else begin
      wdata_valid = ($urandom_range(0, 4) != 0);
      wdata_strb  = 2'($urandom);
    end
  endtask

  // abort_rel: -1 none, -2 random cycle of the transaction, >=0 reset at d0+abort_rel.
  task automatic run_txn(input bit w, input bit z, input int len, input bit rs,
                         input bit rnd, input int gap, input int abort_rel);
    int t0, n, d0, d1, stop;
    t0 = cyc;
    n  = z ? 0 : (rs ? 2 * LC : LC);
    d0 = t0 + 4 + n;
    d1 = d0 + len;
    stop = d1 + 1;
    if (abort_rel == -2) stop = t0 + 1 + $urandom_range(0, d1 - t0);
    else if (abort_rel >= 0) stop = d0 + abort_rel;
    cmd_valid = 1'b1; cmd_wr = w; cmd_zlat = z; cmd_len = LW'(len); rwds_sampled = rs;
    drive_w(d0, gap, rnd);
    while (cyc < stop) begin
      tick();
      cmd_valid    = ($urandom_range(0, 3) == 0);
      cmd_wr       = 1'($urandom);
      cmd_zlat     = 1'($urandom);
      cmd_len      = LW'($urandom);
      rwds_sampled = (cyc <= t0 + 3) ? rs : 1'($urandom);
      drive_w(d0, gap, rnd);
    end
    if (abort_rel != -1) begin
      rst = 1'b1;
      cmd_valid = 1'b0;
    end
    tick();
    rst = 1'b0;
    cmd_valid = 1'b0;
    rwds_sampled = 1'($urandom);
    drive_w(d0, gap, rnd);
  endtask

  // Transaction-level reference: outputs follow from T, N, L and the previous strobe.
  bit m_rst_prev = 1'b1;
  bit m_active = 1'b0;
  bit m_lat = 1'b0, m_lat_new = 1'b0;
  bit m_wr, m_zlat, m_pv;
  logic [1:0] m_ps;
  int m_T, m_N, m_L;
  logic cap_t [0:4095];
  logic cap_done [0:4095];
  logic cap_ready [0:4095];
  logic cap_busy [0:4095];
  logic cap_lat [0:4095];
  logic cap_und [0:4095];
  logic cap_wrdy [0:4095];
  logic [1:0] cap_sdr [0:4095];

  always @(negedge clk) begin
    bit e_ready, e_busy, e_done, e_und, e_t, e_wrdy, me;
    logic [1:0] e_sdr;
    int d0, d1;
    if (cyc > 20000) begin
      $display("FAIL timeout at cycle %0d", cyc);
      $fatal(1, "cycle budget exhausted");
    end
    if (cyc >= 1) begin
      e_ready = 1'b1; e_busy = 1'b0; e_done = 1'b0; e_und = 1'b0;
      e_t = 1'b1; e_sdr = 2'b00; e_wrdy = 1'b0;
      if (m_rst_prev) begin
        m_active = 1'b0;
        m_lat = 1'b0;
      end else if (m_active) begin
        if (cyc == m_T + 4) begin
          m_lat = m_lat_new;
          m_N = m_zlat ? 0 : (m_lat_new ? 2 * LC : LC);
        end
        if (cyc >= m_T + 4 && cyc > m_T + 5 + m_N + m_L) m_active = 1'b0;
        if (m_active) begin
          e_busy = 1'b1;
          e_ready = 1'b0;
          if (cyc >= m_T + 4) begin
            d0 = m_T + 4 + m_N;
            d1 = d0 + m_L;
            me = m_wr && !m_zlat;
            e_wrdy = me && cyc >= d0 && cyc <= d1;
            e_t = !(me && cyc >= d0 && cyc <= d1 + 1);
            if (me && cyc >= d0 + 1 && cyc <= d1 + 1) begin
              e_sdr = m_pv ? ~m_ps : 2'b11;
              e_und = !m_pv;
            end
            e_done = (cyc == d1 + 1);
          end
        end
        if (m_active && cyc == m_T + 3) m_lat_new = rwds_sampled;
      end
      chk("cmd_ready", cmd_ready, e_ready);
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      chk("underrun", underrun, e_und);
      chk("rwds_t", rwds_t, e_t);
      chk("rwds_sdr", rwds_sdr, e_sdr);
      chk("wdata_ready", wdata_ready, e_wrdy);
      chk("lat_2x", lat_2x, m_lat);
      if (cyc < 4096) begin
        cap_t[cyc] = rwds_t; cap_done[cyc] = done; cap_ready[cyc] = cmd_ready;
        cap_busy[cyc] = busy; cap_lat[cyc] = lat_2x; cap_und[cyc] = underrun;
        cap_wrdy[cyc] = wdata_ready; cap_sdr[cyc] = rwds_sdr;
      end
      if (!rst && !m_active && cmd_valid) begin
        m_active = 1'b1; m_T = cyc; m_wr = cmd_wr; m_zlat = cmd_zlat; m_L = int'(cmd_len);
      end
      m_rst_prev = rst; m_pv = wdata_valid; m_ps = wdata_strb;
      // Fixed-latency read with handshake at 10: N=12, L=7.
      if (cyc <= 60) begin
        chk("fix_rwds_t", f_rwds_t, 1'b1);
        chk("fix_rwds_sdr", f_rwds_sdr, 2'b00);
        chk("fix_wdata_ready", f_wdata_ready, 1'b0);
        chk("fix_underrun", f_underrun, 1'b0);
        chk("fix_done", f_done, cyc == 34);
        chk("fix_busy", f_busy, cyc >= 11 && cyc <= 34);
        chk("fix_cmd_ready", f_cmd_ready, !(cyc >= 11 && cyc <= 34));
        chk("fix_lat_2x", f_lat_2x, cyc >= 14);
      end
    end
  end

  initial begin
    f_rst = 1'b1; f_cmd_valid = 1'b0; f_cmd_wr = 1'b0; f_cmd_zlat = 1'b0;
    f_cmd_len = 16'd7; f_rwds_sampled = 1'b0; f_wdata_valid = 1'b0; f_wdata_strb = 2'b00;
    while (cyc < 3) tick();
    f_rst = 1'b0;
    while (cyc < 10) tick();
    f_cmd_valid = 1'b1;
    tick();
    f_cmd_valid = 1'b0;
    repeat (60) begin
      tick();
      f_wdata_valid = 1'($urandom);
      f_wdata_strb = 2'($urandom);
    end
  end

  logic [1:0] s1_pat [0:4] = '{2'b00, 2'b00, 2'b10, 2'b01, 2'b11};

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_zlat = 1'b0; cmd_len = '0;
    rwds_sampled = 1'b0; wdata_valid = 1'b0; wdata_strb = 2'b00;
    while (cyc < 3) tick();
    rst = 1'b0;
    while (cyc < 10) tick();
    run_txn(1'b1, 1'b0, 3, 1'b0, 1'b0, -1, -1);   // T=10
    run_txn(1'b1, 1'b0, 3, 1'b1, 1'b0, -1, -1);   // T=25, doubled latency
    run_txn(1'b1, 1'b1, 0, 1'b0, 1'b1, -1, -1);   // T=46, zero-latency write
    run_txn(1'b1, 1'b0, 1, 1'b0, 1'b0, 1, -1);    // T=52, second word missing
    run_txn(1'b1, 1'b0, 3, 1'b0, 1'b0, -1, 1);    // T=65, reset in second DATA cycle
    run_txn(1'b1, 1'b0, 3, 1'b0, 1'b0, -1, -1);   // T=77, repeat of the first
    run_txn(1'b1, 1'b0, 63, 1'b0, 1'b1, -1, -1);  // T=92, maximum length
    repeat (60) begin
      repeat ($urandom_range(0, 2)) tick();
      run_txn(1'($urandom), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 7) == 0) ? 63 : int'($urandom_range(0, 12)),
              1'($urandom), 1'b1, -1, ($urandom_range(0, 7) == 0) ? -2 : -1);
    end
    repeat (3) tick();

    for (int i = 0; i < 5; i++) begin
      chk("s1_rwds_t", cap_t[20 + i], 1'b0);
      chk("s1_rwds_sdr", cap_sdr[20 + i], s1_pat[i]);
      chk("s6_rwds_t", cap_t[87 + i], 1'b0);
      chk("s6_rwds_sdr", cap_sdr[87 + i], s1_pat[i]);
      chk("s2_rwds_t", cap_t[41 + i], 1'b0);
    end
    chk("s1_pre_t", cap_t[19], 1'b1);
    chk("s1_post_t", cap_t[25], 1'b1);
    chk("s1_wrdy_last", cap_wrdy[23], 1'b1);
    chk("s1_wrdy_after", cap_wrdy[24], 1'b0);
    chk("s1_done", cap_done[24], 1'b1);
    chk("s1_done_early", cap_done[23], 1'b0);
    chk("s1_ready_busy", cap_ready[24], 1'b0);
    chk("s1_ready", cap_ready[25], 1'b1);
    chk("s1_lat", cap_lat[14], 1'b0);
    chk("s2_pre_t", cap_t[40], 1'b1);
    chk("s2_post_t", cap_t[46], 1'b1);
    chk("s2_done", cap_done[45], 1'b1);
    chk("s2_lat_old", cap_lat[28], 1'b0);
    chk("s2_lat_new", cap_lat[29], 1'b1);
    chk("s3_rwds_t", cap_t[50], 1'b1);
    chk("s3_wrdy", cap_wrdy[50], 1'b0);
    chk("s3_done", cap_done[51], 1'b1);
    chk("s3_ready", cap_ready[52], 1'b1);
    chk("s4_first_mask", cap_sdr[63], 2'b00);
    chk("s4_gap_mask", cap_sdr[64], 2'b11);
    chk("s4_underrun", cap_und[64], 1'b1);
    chk("s4_no_underrun", cap_und[63], 1'b0);
    chk("s4_done", cap_done[64], 1'b1);
    chk("s5_driving", cap_t[76], 1'b0);
    chk("s5_reset_t", cap_t[77], 1'b1);
    chk("s5_reset_sdr", cap_sdr[77], 2'b00);
    chk("s5_reset_busy", cap_busy[77], 1'b0);
    chk("s5_reset_ready", cap_ready[77], 1'b1);
    for (int c = 76; c <= 90; c++) chk("s5_no_done", cap_done[c], 1'b0);
    chk("s6_done", cap_done[91], 1'b1);
    chk("s7_wrdy_last", cap_wrdy[165], 1'b1);
    chk("s7_wrdy_after", cap_wrdy[166], 1'b0);
    chk("s7_done_early", cap_done[165], 1'b0);
    chk("s7_done", cap_done[166], 1'b1);
    chk("s7_ready", cap_ready[167], 1'b1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
